fetch_queue: RTL and testbench



---
 rtl/fetch_queue_if.sv | 26 ++
 rtl/fetch_queue.sv | 154 +++++++++++++++
 tb/tb_fetch_queue.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Instruction-memory request/response bus between the fetch queue and memory.
// The master side (fetch_queue) issues requests; the slave side (memory)
// grants them and returns data in issue order.
interface fetch_queue_if;
   logic        fetch_req_o;
   logic [31:0] fetch_addr_o;
   logic        fetch_gnt_i;
   logic        fetch_rvalid_i;
   logic [31:0] fetch_data_i;

   modport master (
      output fetch_req_o,
      output fetch_addr_o,
      input  fetch_gnt_i,
      input  fetch_rvalid_i,
      input  fetch_data_i
   );

   modport slave (
      input  fetch_req_o,
      input  fetch_addr_o,
      output fetch_gnt_i,
      output fetch_rvalid_i,
      output fetch_data_i
   );
endinterface

// File: rtl/fetch_queue.sv
// Decoupled instruction-fetch front end: owns the PC, keeps up to DEPTH
// requests outstanding against an in-order memory, buffers returned
// instructions with their addresses and hands them to decode. A jump empties
// the queue and turns every outstanding response into a discard.
module fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        jump_en_i,
   input  logic [31:0] jump_addr_i,
   input  logic        hold_flag_i,
   fetch_queue_if.master mem,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_addr_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW:0] C_DEPTH_W = (CW+1)'(DEPTH);
   localparam logic [CW-1:0] C_DEPTH = CW'(DEPTH);

   logic [31:0]   r_pc;
   logic [31:0]   r_rsp_pc;
   logic [31:0]   r_inst [DEPTH];
   logic [31:0]   r_addr [DEPTH];
   logic [PW-1:0] r_rd_ptr;
   logic [PW-1:0] r_wr_ptr;
   logic [CW-1:0] r_count;
   logic [CW-1:0] r_inflight;
   logic [CW-1:0] r_discard;

   logic [31:0]   w_jump_target;
   logic [CW:0]   w_credit_used;
   logic          w_req;
   logic          w_issue;
   logic          w_empty;
   logic          w_push;
   logic          w_drop;
   logic          w_pop;
   logic [CW-1:0] w_count_nxt;
   logic [CW-1:0] w_inflight_nxt;
   logic [CW-1:0] w_discard_nxt;

   // Masking keeps all jump_addr_i bits in use while forcing word alignment.
   assign w_jump_target = jump_addr_i & 32'hFFFF_FFFC;

   // Slots already spoken for: buffered entries plus responses that will be kept.
   assign w_credit_used = {1'b0, r_count} + {1'b0, r_inflight} - {1'b0, r_discard};

   assign w_req   = !rst && !jump_en_i && (r_inflight < C_DEPTH) && (w_credit_used < C_DEPTH_W);
   assign w_issue = w_req && mem.fetch_gnt_i;
   assign w_empty = (r_count == {CW{1'b0}});
   assign w_pop   = !w_empty && !hold_flag_i && !jump_en_i;
   assign w_push  = mem.fetch_rvalid_i && !jump_en_i && (r_discard == {CW{1'b0}});
   assign w_drop  = mem.fetch_rvalid_i && !jump_en_i && (r_discard != {CW{1'b0}});

   assign mem.fetch_req_o  = w_req;
   assign mem.fetch_addr_o = r_pc;

   assign inst_valid_o = !w_empty;
   assign inst_o       = w_empty ? NOP_INST : r_inst[r_rd_ptr];
   assign inst_addr_o  = w_empty ? 32'h0000_0000 : r_addr[r_rd_ptr];

   // Next values of the occupancy, in-flight and discard counters; a jump wins.
   always_comb begin
      w_count_nxt    = r_count;
      w_discard_nxt  = r_discard;
      w_inflight_nxt = r_inflight + CW'(w_issue) - CW'(mem.fetch_rvalid_i);
      if (jump_en_i) begin
         // Everything still outstanding after this cycle's response is stale.
         w_count_nxt   = {CW{1'b0}};
         w_discard_nxt = r_inflight - CW'(mem.fetch_rvalid_i);
      end else begin
         w_count_nxt   = r_count + CW'(w_push) - CW'(w_pop);
         w_discard_nxt = r_discard - CW'(w_drop);
      end
   end

   // PC, response PC, queue pointers and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc       <= RESET_PC;
         r_rsp_pc   <= RESET_PC;
         r_rd_ptr   <= {PW{1'b0}};
         r_wr_ptr   <= {PW{1'b0}};
         r_count    <= {CW{1'b0}};
         r_inflight <= {CW{1'b0}};
         r_discard  <= {CW{1'b0}};
      end else begin
         r_count    <= w_count_nxt;
         r_inflight <= w_inflight_nxt;
         r_discard  <= w_discard_nxt;
         if (jump_en_i) begin
            r_pc     <= w_jump_target;
            r_rsp_pc <= w_jump_target;
            r_rd_ptr <= {PW{1'b0}};
            r_wr_ptr <= {PW{1'b0}};
         end else begin
            if (w_issue) begin
               r_pc <= r_pc + 32'd4;
            end
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + PW'(1);
               r_rsp_pc <= r_rsp_pc + 32'd4;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + PW'(1);
            end
         end
      end
   end

   // Queue storage; contents are qualified by the count, so no reset needed.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_inst[r_wr_ptr] <= mem.fetch_data_i;
         r_addr[r_wr_ptr] <= r_rsp_pc;
      end
   end

   fetch_queue_chk #(.DEPTH(DEPTH)) u_chk (
      .clk      (clk),
      .rst      (rst),
      .i_push   (w_push),
      .i_rvalid (mem.fetch_rvalid_i),
      .i_count  (r_count),
      .i_inflight (r_inflight)
   );
endmodule

// Design-error checks for the fetch queue.
module fetch_queue_chk #(
   parameter int DEPTH = 4
) (
   input logic                       clk,
   input logic                       rst,
   input logic                       i_push,
   input logic                       i_rvalid,
   input logic [$clog2(DEPTH):0]     i_count,
   input logic [$clog2(DEPTH):0]     i_inflight
);
   localparam int CW = $clog2(DEPTH) + 1;

   // The credit rule must never let a response land in a full queue.
   a_no_push_when_full : assert property (@(posedge clk) disable iff (rst)
      !(i_push && (i_count == CW'(DEPTH))));

   // A response with nothing outstanding means the memory broke ordering.
   a_no_orphan_rvalid : assert property (@(posedge clk) disable iff (rst)
      !(i_rvalid && (i_inflight == {CW{1'b0}})));
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: an in-order memory with configurable
// latency, a queue-based reference model, a directed table, corner sequences
// and a randomized run.
module tb_fetch_queue;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst;
   logic        jump_en_i;
   logic [31:0] jump_addr_i;
   logic        hold_flag_i;
   logic        inst_valid_o;
   logic [31:0] inst_o;
   logic [31:0] inst_addr_o;

   fetch_queue_if mem_if ();

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC), .NOP_INST(NOP)) dut (
      .clk          (clk),
      .rst          (rst),
      .jump_en_i    (jump_en_i),
      .jump_addr_i  (jump_addr_i),
      .hold_flag_i  (hold_flag_i),
      .mem          (mem_if),
      .inst_valid_o (inst_valid_o),
      .inst_o       (inst_o),
      .inst_addr_o  (inst_addr_o)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Reference model: fetch PC, response PC, buffered entries, and one tag per
   // outstanding request (1 = will be discarded).
   typedef struct { logic [31:0] inst; logic [31:0] addr; } ent_t;
   typedef struct { logic [31:0] addr; int ready; } pend_t;
   logic [31:0] m_pc;
   logic [31:0] m_rsp_pc;
   ent_t        m_q[$];
   bit          m_tag[$];
   bit          m_live = 1'b0;
   // Memory: outstanding requests with the cycle their data becomes ready.
   pend_t       pend[$];
   int          cyc = 0;
   int          mem_lat = 1;
   bit          rand_lat = 1'b0;

   function automatic logic [31:0] memval(input logic [31:0] a);
      return (a * 32'h9E37_79B9) ^ 32'hC0DE_0000;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle: compare state at the falling edge, drive inputs, compare
   // the request, then advance the model to what the next rising edge does.
   task automatic step(input logic hold, input logic jump, input logic [31:0] jaddr,
                       input logic gnt, input logic rstv);
      logic        rv;
      logic [31:0] rd;
      logic        exp_req;
      bit          drop;
      int          kept;
      int          lat;
      @(negedge clk);
      if (m_live) begin
         chk("inst_valid", 32'(inst_valid_o), 32'(m_q.size() > 0));
         chk("inst", inst_o, (m_q.size() > 0) ? m_q[0].inst : NOP);
         chk("inst_addr", inst_addr_o, (m_q.size() > 0) ? m_q[0].addr : 32'h0000_0000);
         chk("fetch_addr", mem_if.fetch_addr_o, m_pc);
      end
      rv = !rstv && (pend.size() > 0) && (pend[0].ready <= cyc);
      rd = rv ? memval(pend[0].addr) : $urandom;
      rst = rstv;
      hold_flag_i = hold;
      jump_en_i = jump;
      jump_addr_i = jaddr;
      mem_if.fetch_gnt_i = gnt;
      mem_if.fetch_rvalid_i = rv;
      mem_if.fetch_data_i = rd;
      #1;
      kept = 0;
      foreach (m_tag[i]) if (!m_tag[i]) kept++;
      exp_req = !rstv && !jump && (m_tag.size() < DEPTH) && ((m_q.size() + kept) < DEPTH);
      if (m_live || rstv) chk("fetch_req", 32'(mem_if.fetch_req_o), 32'(exp_req));
      if (rstv) begin
         m_pc = RESET_PC;
         m_rsp_pc = RESET_PC;
         m_q.delete();
         m_tag.delete();
         pend.delete();
         m_live = 1'b1;
      end else begin
         drop = 1'b1;
         if (rv) begin
            void'(pend.pop_front());
            drop = m_tag.pop_front();
         end
         if (jump) begin
            m_q.delete();
            m_pc = jaddr & 32'hFFFF_FFFC;
            m_rsp_pc = m_pc;
            foreach (m_tag[i]) m_tag[i] = 1'b1;
         end else begin
            if ((m_q.size() > 0) && !hold) void'(m_q.pop_front());
            if (rv && !drop) begin
               m_q.push_back('{inst: rd, addr: m_rsp_pc});
               m_rsp_pc = m_rsp_pc + 32'd4;
            end
            if (exp_req && gnt) begin
               lat = rand_lat ? int'($urandom_range(1, 4)) : mem_lat;
               m_tag.push_back(1'b0);
               pend.push_back('{addr: m_pc, ready: cyc + lat});
               m_pc = m_pc + 32'd4;
            end
         end
      end
      cyc++;
   endtask

   task automatic do_reset();
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
   endtask

   // Run until decode sees a valid head (bounded) and check its address.
   task automatic wait_valid(input string name, input logic [31:0] exp_addr);
      for (int i = 0; i < 20; i++) begin
         step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
         if (inst_valid_o) begin
            chk(name, inst_addr_o, exp_addr);
            return;
         end
      end
      checks++;
      failures++;
      $display("FAIL %s_timeout: got no valid expected valid within 20 cycles", name);
   endtask

   typedef struct {
      logic        hold;
      logic        exp_req;
      logic [31:0] exp_fa;
      logic        exp_v;
      logic [31:0] exp_ia;
   } vec_t;
   vec_t vecs[11];

   logic [31:0] saved_pc;

   initial begin
      rst = 1'b1;
      jump_en_i = 1'b0;
      jump_addr_i = 32'h0;
      hold_flag_i = 1'b0;
      mem_if.fetch_gnt_i = 1'b0;
      mem_if.fetch_rvalid_i = 1'b0;
      mem_if.fetch_data_i = 32'h0;

      // Streaming start, then hold from the first valid until the queue fills.
      vecs[0]  = '{1'b0, 1'b1, 32'h00, 1'b0, 32'h00};
      vecs[1]  = '{1'b0, 1'b1, 32'h04, 1'b0, 32'h00};
      vecs[2]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h00};
      vecs[3]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h00};
      vecs[4]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
      vecs[5]  = '{1'b1, 1'b0, 32'h10, 1'b1, 32'h00};
      vecs[6]  = '{1'b0, 1'b0, 32'h10, 1'b1, 32'h00};
      vecs[7]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h04};
      vecs[8]  = '{1'b0, 1'b1, 32'h14, 1'b1, 32'h08};
      vecs[9]  = '{1'b0, 1'b1, 32'h18, 1'b1, 32'h0C};
      vecs[10] = '{1'b0, 1'b1, 32'h1C, 1'b1, 32'h10};

      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
      do_reset();
      mem_lat = 1;
      for (int i = 0; i < 11; i++) begin
         step(vecs[i].hold, 1'b0, 32'h0, 1'b1, 1'b0);
         chk($sformatf("tbl%0d_req", i), 32'(mem_if.fetch_req_o), 32'(vecs[i].exp_req));
         chk($sformatf("tbl%0d_faddr", i), mem_if.fetch_addr_o, vecs[i].exp_fa);
         chk($sformatf("tbl%0d_valid", i), 32'(inst_valid_o), 32'(vecs[i].exp_v));
         chk($sformatf("tbl%0d_iaddr", i), inst_addr_o, vecs[i].exp_ia);
         chk($sformatf("tbl%0d_inst", i), inst_o, vecs[i].exp_v ? memval(vecs[i].exp_ia) : NOP);
      end

      // Jump with three requests in flight against a 3-cycle memory.
      do_reset();
      mem_lat = 3;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
      wait_valid("jump_inflight_first", 32'h100);

      // Jump in the same cycle as a response and a pending pop.
      do_reset();
      mem_lat = 1;
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      step(1'b0, 1'b1, 32'h100, 1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("jump_pop_valid", 32'(inst_valid_o), 32'h0);
      chk("jump_pop_faddr", mem_if.fetch_addr_o, 32'h100);
      wait_valid("jump_pop_first", 32'h100);

      // Misaligned jump target.
      step(1'b0, 1'b1, 32'h203, 1'b1, 1'b0);
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
      chk("misalign_faddr", mem_if.fetch_addr_o, 32'h200);
      wait_valid("misalign_iaddr", 32'h200);

      // Grant withheld for five cycles: PC frozen, then streaming resumes.
      saved_pc = m_pc;
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
         chk("nognt_faddr", mem_if.fetch_addr_o, saved_pc);
      end
      for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

      // Randomized run against the model, including PC wrap and mid-run reset.
      rand_lat = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         logic        h, j, g, r;
         logic [31:0] a;
         h = ($urandom_range(0, 99) < 30);
         j = ($urandom_range(0, 99) < 3);
         g = ($urandom_range(0, 99) < 70);
         r = ($urandom_range(0, 999) < 5);
         a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFE0 | ($urandom & 32'h0000_001F)) : $urandom;
         step(h, j, a, g, r);
      end
      rand_lat = 1'b0;
      step(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
